// File: rtl/nofx2_event_framer.sv
// nofx2_event_framer
//   Store-and-forward framer in front of the nofx2 event buffer. Payload words
//   of one event are collected into a local RAM; once the final word arrives the
//   frame is emitted as: type, L, payload[0..L-1] (plus a checksum word when
//   enabled). After every reset the event buffer is reset through a
//   request/acknowledge handshake before any payload is accepted.
//
//   Build option: define NOFX2_FRAMER_CHECKSUM_EN to append a 16-bit wrapping
//   sum of the payload words after the payload (L then counts that word too,
//   and one less payload word fits in the RAM).
//
// Ports
//   wr_clk         sole clock
//   rst_i          synchronous active-high reset
//   src_type_i     frame type, sampled with the first payload word
//   src_dat_i      payload word
//   src_valid_i    payload word valid
//   src_last_i     final payload word of the frame
//   src_ready_o    framer accepts a word this cycle
//   buf_dat_o      word presented to the event buffer
//   buf_wr_o       write strobe to the event buffer (never while full)
//   buf_full_i     event buffer full
//   buf_rst_o      reset request to the event buffer
//   buf_rst_ack_i  event buffer reset acknowledge
//   frame_cnt_o    frames emitted, wrapping
//   err_o          sticky oversize-frame-dropped flag
module nofx2_event_framer #(
    parameter int ADDR_BITS = 11
) (
    input  logic        wr_clk,
    input  logic        rst_i,
    input  logic [15:0] src_type_i,
    input  logic [15:0] src_dat_i,
    input  logic        src_valid_i,
    input  logic        src_last_i,
    output logic        src_ready_o,
    output logic [15:0] buf_dat_o,
    output logic        buf_wr_o,
    input  logic        buf_full_i,
    output logic        buf_rst_o,
    input  logic        buf_rst_ack_i,
    output logic [15:0] frame_cnt_o,
    output logic        err_o
);

    localparam int DEPTH = 2 ** ADDR_BITS;
`ifdef NOFX2_FRAMER_CHECKSUM_EN
    localparam int CHK_W = 1;
`else
    localparam int CHK_W = 0;
`endif
    // Write index at which a non-final word means the frame cannot fit.
    localparam logic [ADDR_BITS-1:0] OVF_IDX = ADDR_BITS'(DEPTH - 2 - CHK_W);

    typedef enum logic [2:0] {
        BRST_REQ, BRST_WAIT, FILL, DROP, HDR_T, HDR_L, PAYLD, CHKSUM
    } state_t;

    state_t                 state_q, state_n;
    logic [ADDR_BITS-1:0]   cnt_q;
    logic [ADDR_BITS-1:0]   ptr_q;
    logic [ADDR_BITS-1:0]   last_idx_q;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [15:0]            type_q;
    logic [15:0]            len_q;
    logic [15:0]            rd_q;
    logic [15:0]            frame_cnt_q;
    logic                   err_q;
    logic                   brst_q;
    logic                   ready_c;
    logic                   present_c;
    logic                   done_c;
    logic                   xfer;
    logic                   wr;
    logic [15:0]            ram [DEPTH];
`ifdef NOFX2_FRAMER_CHECKSUM_EN
    logic [15:0]            sum_q;
`endif

    // Outputs are gated off while reset is held so nothing leaks out during it.
    assign src_ready_o = ready_c & ~rst_i;
    assign xfer        = src_valid_i & src_ready_o;
    assign wr          = present_c & ~buf_full_i & ~rst_i;
    assign buf_wr_o    = wr;
    assign buf_rst_o   = brst_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_o       = err_q;

    always_comb begin
        state_n   = state_q;
        ready_c   = 1'b0;
        present_c = 1'b0;
        done_c    = 1'b0;
        buf_dat_o = 16'h0000;
        rd_addr   = ptr_q;
        case (state_q)
            BRST_REQ: begin
                // Only accept an ack once the request has actually been driven.
                if (brst_q && buf_rst_ack_i) state_n = BRST_WAIT;
            end
            BRST_WAIT: begin
                if (!buf_rst_ack_i) state_n = FILL;
            end
            FILL: begin
                ready_c = 1'b1;
                if (xfer) begin
                    if (src_last_i)            state_n = HDR_T;
                    else if (cnt_q == OVF_IDX) state_n = DROP;
                end
            end
            DROP: begin
                ready_c = 1'b1;
                if (xfer && src_last_i) state_n = FILL;
            end
            HDR_T: begin
                present_c = 1'b1;
                buf_dat_o = type_q;
                if (wr) state_n = HDR_L;
            end
            HDR_L: begin
                // Prefetch payload word 0 so PAYLD can stream at full rate.
                present_c = 1'b1;
                buf_dat_o = len_q;
                rd_addr   = '0;
                if (wr) state_n = PAYLD;
            end
            PAYLD: begin
                present_c = 1'b1;
                buf_dat_o = rd_q;
                if (wr) begin
                    rd_addr = ptr_q + 1'b1;
                    if (ptr_q == last_idx_q) begin
`ifdef NOFX2_FRAMER_CHECKSUM_EN
                        state_n = CHKSUM;
`else
                        state_n = FILL;
                        done_c  = 1'b1;
`endif
                    end
                end
            end
`ifdef NOFX2_FRAMER_CHECKSUM_EN
            CHKSUM: begin
                present_c = 1'b1;
                buf_dat_o = sum_q;
                if (wr) begin
                    state_n = FILL;
                    done_c  = 1'b1;
                end
            end
`endif
            default: state_n = BRST_REQ;
        endcase
    end

    // Control state
    always_ff @(posedge wr_clk) begin
        if (rst_i) begin
            state_q     <= BRST_REQ;
            cnt_q       <= '0;
            ptr_q       <= '0;
            frame_cnt_q <= 16'h0000;
            err_q       <= 1'b0;
            brst_q      <= 1'b0;
        end else begin
            state_q <= state_n;
            brst_q  <= (state_n == BRST_REQ);
            if (state_q == FILL && xfer)
                cnt_q <= (state_n == FILL) ? cnt_q + 1'b1 : '0;
            else if (state_q != FILL)
                cnt_q <= '0;
            if (state_q == FILL && xfer && !src_last_i && cnt_q == OVF_IDX)
                err_q <= 1'b1;
            if (state_q == HDR_L)
                ptr_q <= '0;
            else if (state_q == PAYLD && wr)
                ptr_q <= ptr_q + 1'b1;
            if (done_c)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    // Payload storage and frame datapath
    always_ff @(posedge wr_clk) begin
        if (state_q == FILL && xfer) begin
            ram[cnt_q] <= src_dat_i;
            if (cnt_q == '0) type_q <= src_type_i;
            if (src_last_i) begin
                last_idx_q <= cnt_q;
                len_q      <= 16'(cnt_q) + 16'(1 + CHK_W);
            end
`ifdef NOFX2_FRAMER_CHECKSUM_EN
            sum_q <= (cnt_q == '0) ? src_dat_i : sum_q + src_dat_i;
`endif
        end
        rd_q <= ram[rd_addr];
    end

endmodule

// File: tb/tb_nofx2_event_framer.sv
module tb_nofx2_event_framer;

    localparam int ADDR_BITS = 4;
    localparam int DEPTH     = 2 ** ADDR_BITS;
`ifdef NOFX2_FRAMER_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int MAXPAY = DEPTH - 1 - CHK;

    logic        wr_clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] src_type_i = '0;
    logic [15:0] src_dat_i = '0;
    logic        src_valid_i = 1'b0;
    logic        src_last_i = 1'b0;
    logic        src_ready_o;
    logic [15:0] buf_dat_o;
    logic        buf_wr_o;
    logic        buf_full_i = 1'b0;
    logic        buf_rst_o;
    logic        buf_rst_ack_i = 1'b0;
    logic [15:0] frame_cnt_o;
    logic        err_o;

    nofx2_event_framer #(.ADDR_BITS(ADDR_BITS)) dut (
        .wr_clk(wr_clk), .rst_i(rst_i),
        .src_type_i(src_type_i), .src_dat_i(src_dat_i),
        .src_valid_i(src_valid_i), .src_last_i(src_last_i), .src_ready_o(src_ready_o),
        .buf_dat_o(buf_dat_o), .buf_wr_o(buf_wr_o), .buf_full_i(buf_full_i),
        .buf_rst_o(buf_rst_o), .buf_rst_ack_i(buf_rst_ack_i),
        .frame_cnt_o(frame_cnt_o), .err_o(err_o)
    );

    always #5 wr_clk = ~wr_clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    logic [15:0] pl[$];
    int          exp_frames = 0;
    logic        exp_err = 1'b0;
    logic        full_en = 1'b0;
    logic        full_force = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Buffer-side back-pressure.
    initial forever begin
        @(posedge wr_clk); #1;
        buf_full_i = full_force | (full_en & ($urandom_range(0, 3) == 0));
    end

    // Capture every word the buffer would accept.
    always @(negedge wr_clk) begin
        if (buf_wr_o) begin
            chk("wr_while_full", {31'd0, buf_full_i}, 32'd0);
            got.push_back(buf_dat_o);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a frame of n payload words either fits (emitted as
    // type, L, words, optional sum) or is dropped and flags the error.
    task automatic model_frame(input logic [15:0] typ);
        logic [15:0] s;
        int n;
        n = pl.size();
        s = 16'h0000;
        if (n <= MAXPAY) begin
            exp_q.push_back(typ);
            exp_q.push_back(16'(n + CHK));
            foreach (pl[i]) begin
                exp_q.push_back(pl[i]);
                s = s + pl[i];
            end
            if (CHK == 1) exp_q.push_back(s);
            exp_frames++;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic send(input logic [15:0] typ);
        int  t;
        bit  acc;
        int  n;
        n = pl.size();
        @(posedge wr_clk); #1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                src_valid_i = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge wr_clk);
                #1;
            end
            src_valid_i = 1'b1;
            src_dat_i   = pl[i];
            src_type_i  = (i == 0) ? typ : 16'($urandom);
            src_last_i  = (i == n - 1);
            t = 0;
            do begin
                @(negedge wr_clk);
                acc = src_ready_o;
                @(posedge wr_clk); #1;
                t++;
            end while (!acc && t < 400);
            if (!acc) begin
                chk("src_ready_timeout", {31'd0, acc}, 32'd1);
                break;
            end
        end
        src_valid_i = 1'b0;
        src_last_i  = 1'b0;
        model_frame(typ);
    endtask

    task automatic drain(input string tag);
        int t;
        int m;
        t = 0;
        while (got.size() < exp_q.size() && t < 800) begin
            @(negedge wr_clk);
            t++;
        end
        repeat (4) @(negedge wr_clk);
        chk({tag, "_nwords"}, got.size(), exp_q.size());
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_word%0d", tag, i), {16'd0, got[i]}, {16'd0, exp_q[i]});
        chk({tag, "_frame_cnt"}, {16'd0, frame_cnt_o}, 32'(exp_frames[15:0]));
        chk({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
        got.delete();
        exp_q.delete();
    endtask

    // Reset, then buffer handshake: ack rises 3 clk into the request, falls 2 clk later.
    task automatic reset_seq();
        @(posedge wr_clk); #1;
        rst_i = 1'b1;
        src_valid_i = 1'b0;
        buf_rst_ack_i = 1'b0;
        got.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_err = 1'b0;
        @(negedge wr_clk);
        chk("rst_wr_gated", {31'd0, buf_wr_o}, 32'd0);
        @(posedge wr_clk); #1;
        rst_i = 1'b0;
        @(negedge wr_clk);
        chk("rst_buf_rst", {31'd0, buf_rst_o}, 32'd0);
        chk("rst_ready", {31'd0, src_ready_o}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_dat", {16'd0, buf_dat_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge wr_clk);
            chk("brst_req_high", {31'd0, buf_rst_o}, 32'd1);
            chk("brst_req_notready", {31'd0, src_ready_o}, 32'd0);
        end
        @(posedge wr_clk); #1;
        buf_rst_ack_i = 1'b1;
        @(negedge wr_clk);
        chk("brst_before_ack", {31'd0, buf_rst_o}, 32'd1);
        @(negedge wr_clk);
        chk("brst_after_ack", {31'd0, buf_rst_o}, 32'd0);
        chk("brst_wait_notready", {31'd0, src_ready_o}, 32'd0);
        @(posedge wr_clk); #1;
        buf_rst_ack_i = 1'b0;
        @(negedge wr_clk);
        chk("brst_wait_notready2", {31'd0, src_ready_o}, 32'd0);
        @(negedge wr_clk);
        chk("fill_ready", {31'd0, src_ready_o}, 32'd1);
        chk("handshake_quiet", got.size(), 0);
    endtask

    initial begin
        int t;
        int n0;
        int len;
        repeat (2) @(posedge wr_clk);
        reset_seq();

        // Single-word frame and first-write latency.
        pl = '{16'h080D};
        send(16'h4500);
        @(negedge wr_clk);
        chk("latency_wr", {31'd0, buf_wr_o}, 32'd1);
        chk("latency_type", {16'd0, buf_dat_o}, 32'h4500);
        drain("single");

        // Stall mid-payload for 4 clocks.
        pl = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
        send(16'h1234);
        t = 0;
        while (got.size() < 3 && t < 200) begin
            @(negedge wr_clk);
            t++;
        end
        full_force = 1'b1;
        @(negedge wr_clk);
        n0 = got.size();
        repeat (3) @(negedge wr_clk);
        chk("stall_no_writes", got.size(), n0);
        full_force = 1'b0;
        drain("stall");

        // Oversize frame dropped, next frame intact.
        pl.delete();
        for (int i = 0; i < 21; i++) pl.push_back(16'($urandom));
        send(16'hBAD0);
        pl = '{16'h1111, 16'h2222};
        send(16'h0B0B);
        drain("oversize");

        // Largest frame that fits, and one word beyond it.
        pl.delete();
        for (int i = 0; i < MAXPAY; i++) pl.push_back(16'($urandom));
        send(16'h7F00);
        pl.push_back(16'h5555);
        pl.push_back(16'h6666);
        send(16'h7F01);
        drain("limit");

        // Checksum carry wrap (plain 2-word frame without the option).
        pl = '{16'hFFFF, 16'h0002};
        send(16'h00C5);
        drain("wrapsum");

        // Randomised frames under random back-pressure.
        full_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(MAXPAY - 1, MAXPAY + 3)
                                              : $urandom_range(1, 8);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(16'($urandom));
            send(16'($urandom));
            if (f % 3 == 2) drain($sformatf("rand%0d", f));
        end
        drain("rand_end");
        full_en = 1'b0;

        // Reset in the middle of emitting the third frame.
        reset_seq();
        pl = '{16'h0101};
        send(16'h0001);
        pl = '{16'h0202, 16'h0203};
        send(16'h0002);
        drain("pre_mid");
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(16'h3000 + 16'(i));
        send(16'h0003);
        t = 0;
        while (got.size() < 6 && t < 200) begin
            @(negedge wr_clk);
            t++;
        end
        chk("mid_started", {31'd0, buf_wr_o}, 32'd1);
        reset_seq();
        pl = '{16'hCAFE, 16'hBEEF};
        send(16'h0004);
        drain("post_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
